regfile_wb_arbiter: RTL and testbench

- Write-back scheduler for the 32x32 three-port register file (read ports a1/a2, write port we3/a3/wd3, write on rising clk).
- Shares the single write port between two requesters, ALU result and memory load, using valid/ready handshakes and round-robin priority.
- Keeps a per-register pending scoreboard so the controller can stall reads of registers with an outstanding write.
- Drives we3/a3/wd3 of register_file directly.

---
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the three-port register file: round-robin sharing of the
// single write port between ALU and load results, plus a per-register pending scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] q_a1,
  input  logic [ADDR_W-1:0] q_a2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [0:0] PTR_ALU = 1'b0;
  localparam logic [0:0] PTR_MEM = 1'b1;

  logic [0:0]      ptr_q, ptr_d;
  logic            we3_q, we3_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic [NREG-1:0]   pending_q, pending_d;

  // Readies are gated by rst_n so nothing is accepted while reset is asserted.
  assign alu_ready = rst_n & alu_valid & (~mem_valid | (ptr_q == PTR_ALU));
  assign mem_ready = rst_n & mem_valid & (~alu_valid | (ptr_q == PTR_MEM));
  assign iss_ready = rst_n & ~pending_q[iss_addr];

  assign q_busy1 = pending_q[q_a1];
  assign q_busy2 = pending_q[q_a2];

  assign we3 = we3_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;

  always_comb begin
    ptr_d = ptr_q;
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (alu_ready) begin
      ptr_d = PTR_MEM;
      we3_d = (alu_addr != '0);
      a3_d  = alu_addr;
      wd3_d = alu_data;
    end else if (mem_ready) begin
      ptr_d = PTR_ALU;
      we3_d = (mem_addr != '0);
      a3_d  = mem_addr;
      wd3_d = mem_data;
    end
  end

  // Clear on commit first so a same-edge issue to that register leaves it pending.
  always_comb begin
    pending_d = pending_q;
    if (we3_q) begin
      pending_d[a3_q] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_addr != '0)) begin
      pending_d[iss_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= PTR_ALU;
      we3_q     <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
      pending_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      we3_q     <= we3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write-back latency,
// register-0 handling, scoreboard set/clear and asynchronous reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, iss_valid;
  logic        alu_ready, mem_ready, iss_ready;
  logic [4:0]  alu_addr, mem_addr, iss_addr, q_a1, q_a2, a3;
  logic [31:0] alu_data, mem_data, wd3;
  logic        q_busy1, q_busy2, we3;

  int n_compared   = 0;
  int n_mismatched = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
    .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .we3(we3), .a3(a3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = 5'd0; mem_data = '0;
    iss_valid = 1'b0; iss_addr = 5'd5;
    q_a1 = 5'd0; q_a2 = 5'd0;

    // Reset state
    #1;
    check_bit("rst_alu_ready", alu_ready, 1'b0);
    check_bit("rst_iss_ready", iss_ready, 1'b0);
    alu_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #1;
    check_bit ("rst_we3", we3, 1'b0);
    check_word("rst_a3", 32'(a3), 32'd0);
    check_word("rst_wd3", wd3, 32'd0);
    check_bit ("rst_busy1", q_busy1, 1'b0);
    check_bit ("rst_busy2", q_busy2, 1'b0);
    check_bit ("rst_iss_ready5", iss_ready, 1'b1);
    iss_addr = 5'd31;
    #1;
    check_bit ("rst_iss_ready31", iss_ready, 1'b1);

    // Pointer starts at ALU: with both valid, ALU has ready
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    check_bit("rst_ptr_alu", alu_ready, 1'b1);
    check_bit("rst_ptr_mem", mem_ready, 1'b0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    next_cycle();

    // Single ALU write
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'habcd_efab;
    #1;
    check_bit("solo_alu_ready", alu_ready, 1'b1);
    check_bit("solo_mem_ready", mem_ready, 1'b0);
    next_cycle();
    alu_valid = 1'b0;
    check_bit ("solo_we3", we3, 1'b1);
    check_word("solo_a3", 32'(a3), 32'd1);
    check_word("solo_wd3", wd3, 32'habcd_efab);
    next_cycle();
    check_bit ("solo_we3_off", we3, 1'b0);
    check_word("solo_a3_hold", 32'(a3), 32'd1);
    check_word("solo_wd3_hold", wd3, 32'habcd_efab);

    // Single load write, returns pointer to ALU
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h7777_0007;
    #1;
    check_bit("solo_mem_rdy", mem_ready, 1'b1);
    check_bit("solo_mem_alu_rdy", alu_ready, 1'b0);
    next_cycle();
    mem_valid = 1'b0;
    check_bit ("solo_mem_we3", we3, 1'b1);
    check_word("solo_mem_a3", 32'(a3), 32'd7);
    check_word("solo_mem_wd3", wd3, 32'h7777_0007);

    // Contention: strict alternation ALU, MEM, ALU, MEM
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h0123_4567;
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hcccc_cccc;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_bit($sformatf("arb%0d_alu_ready", i), alu_ready, (i % 2) == 0);
      check_bit($sformatf("arb%0d_mem_ready", i), mem_ready, (i % 2) == 1);
      next_cycle();
      check_bit ($sformatf("arb%0d_we3", i), we3, 1'b1);
      check_word($sformatf("arb%0d_a3", i), 32'(a3), ((i % 2) == 0) ? 32'd2 : 32'd3);
      check_word($sformatf("arb%0d_wd3", i), wd3, ((i % 2) == 0) ? 32'h0123_4567 : 32'hcccc_cccc);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Scoreboard: issue to r3, re-issue stalls, load write clears on commit
    iss_valid = 1'b1; iss_addr = 5'd3; q_a1 = 5'd3; q_a2 = 5'd3;
    #1;
    check_bit("sb_iss_ready", iss_ready, 1'b1);
    check_bit("sb_busy_same_cycle", q_busy1, 1'b0);
    next_cycle();
    check_bit("sb_idle_we3", we3, 1'b0);
    check_bit("sb_busy1_set", q_busy1, 1'b1);
    check_bit("sb_busy2_set", q_busy2, 1'b1);
    check_bit("sb_reissue_stall", iss_ready, 1'b0);
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h3333_4567;
    #1;
    check_bit("sb_mem_ready", mem_ready, 1'b1);
    next_cycle();
    mem_valid = 1'b0;
    check_bit ("sb_we3", we3, 1'b1);
    check_word("sb_a3", 32'(a3), 32'd3);
    check_word("sb_wd3", wd3, 32'h3333_4567);
    check_bit ("sb_busy_during_we3", q_busy1, 1'b1);
    next_cycle();
    check_bit("sb_busy_cleared", q_busy1, 1'b0);
    check_bit("sb_we3_off", we3, 1'b0);

    // Commit to r3 on the same edge as a fresh issue to r3: stays pending
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h5555_aaaa;
    #1;
    check_bit("same_alu_ready", alu_ready, 1'b1);
    next_cycle();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd3;
    #1;
    check_bit("same_we3", we3, 1'b1);
    check_bit("same_iss_ready", iss_ready, 1'b1);
    next_cycle();
    iss_valid = 1'b0;
    check_bit("same_busy_kept", q_busy1, 1'b1);
    check_bit("same_we3_off", we3, 1'b0);

    // Write to r0 is accepted but never enables the register file
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hffff_ffff; q_a2 = 5'd0;
    #1;
    check_bit("r0_alu_ready", alu_ready, 1'b1);
    next_cycle();
    alu_valid = 1'b0;
    check_bit("r0_we3", we3, 1'b0);
    check_bit("r0_busy1_kept", q_busy1, 1'b1);
    check_bit("r0_busy2", q_busy2, 1'b0);

    // Reset in the middle of a write cycle
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h0000_0005;
    next_cycle();
    check_bit("mid_we3_before", we3, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit ("mid_we3_dropped", we3, 1'b0);
    check_word("mid_a3", 32'(a3), 32'd0);
    check_word("mid_wd3", wd3, 32'd0);
    check_bit ("mid_busy_cleared", q_busy1, 1'b0);
    check_bit ("mid_alu_ready", alu_ready, 1'b0);
    check_bit ("mid_iss_ready", iss_ready, 1'b0);
    alu_valid = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    check_bit("post_iss_ready3", iss_ready, 1'b1);
    check_bit("post_we3", we3, 1'b0);

    // Issue to r0 is accepted and marks nothing
    iss_valid = 1'b1; iss_addr = 5'd0;
    #1;
    check_bit("iss0_ready", iss_ready, 1'b1);
    next_cycle();
    iss_valid = 1'b0;
    check_bit("iss0_busy2", q_busy2, 1'b0);
    check_bit("iss0_ready_after", iss_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
